// File: rtl/neuron_accumulator_if.sv
// neuron_accumulator_if: start/bias control, input term stream and output activation handshake.
interface neuron_accumulator_if;
    logic       start;
    logic [7:0] bias;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       busy;
    modport master (output start, bias, in_data, in_valid, out_ready,
                    input  in_ready, out_data, out_valid, busy);
    modport slave  (input  start, bias, in_data, in_valid, out_ready,
                    output in_ready, out_data, out_valid, busy);
endinterface

// File: rtl/neuron_accumulator.sv
// neuron_accumulator: sums bias plus N_INPUTS signed terms, optional ReLU, saturates to 8 bits.
module neuron_accumulator #(
    parameter int N_INPUTS = 4,
    parameter int ACC_W    = 16,
    parameter bit RELU     = 1'b1
) (
    input logic clk,
    input logic rst,
    neuron_accumulator_if.slave bus
);
    localparam int CW = $clog2(N_INPUTS + 1);
    localparam logic signed [ACC_W-1:0] MAX = 127;
    localparam logic signed [ACC_W-1:0] MIN = -128;
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
    state_t state;
    logic signed [ACC_W-1:0] acc, sum, relu_sum;
    logic [CW-1:0] count;
    logic in_ready, out_valid, busy, accept, last;
    logic [7:0] out_data, sat;
    assign accept   = bus.in_valid & in_ready;
    assign last     = accept && count == CW'(N_INPUTS - 1);
    assign sum      = acc + {{(ACC_W-8){bus.in_data[7]}}, bus.in_data};
    assign relu_sum = (RELU && sum < 0) ? '0 : sum;
    assign sat      = relu_sum > MAX ? 8'h7F : relu_sum < MIN ? 8'h80 : relu_sum[7:0];
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_data;
    assign bus.busy      = busy;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            count     <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            busy      <= 1'b0;
        end else if (state == IDLE) begin
            if (bus.start) begin
                acc      <= {{(ACC_W-8){bus.bias[7]}}, bus.bias};
                count    <= '0;
                in_ready <= 1'b1;
                busy     <= 1'b1;
                state    <= ACCUM;
            end
        end else if (state == ACCUM) begin
            if (accept) begin
                acc   <= sum;
                count <= count + CW'(1);
            end
            // the final accept registers the saturated result so DONE holds it stable
            if (last) begin
                in_ready  <= 1'b0;
                out_valid <= 1'b1;
                out_data  <= sat;
                state     <= DONE;
            end
        end else if (bus.out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
        end
    end
endmodule
